ahblite_busmatrix_inputstage_sys: RTL and testbench

AHBLITE_BUSMATRIX_INPUTSTAGE_SYS -- requirements
Module: ahblite_busmatrix_inputstage_sys

---
 rtl/ahblite_busmatrix_inputstage_sys_if.sv | 54 +++++
 rtl/ahblite_busmatrix_inputstage_sys.sv | 154 +++++++++++++++
 tb/tb_ahblite_busmatrix_inputstage_sys.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahblite_busmatrix_inputstage_sys_if.sv
// SYS master port of the bus matrix: master address/response signals plus the
// request/accept/response handshake with the CODE, SRAM and SUB output stages.
interface ahblite_busmatrix_inputstage_sys_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;

  logic [31:0] HADDR_O;
  logic [1:0]  HTRANS_O;
  logic        HWRITE_O;
  logic [2:0]  HSIZE_O;
  logic [2:0]  HBURST_O;
  logic [3:0]  HPROT_O;

  logic        REQ_CODE;
  logic        REQ_SRAM;
  logic        REQ_SUB;
  logic        ACTIVE_CODE;
  logic        ACTIVE_SRAM;
  logic        ACTIVE_SUB;
  logic        HREADYOUT_CODE;
  logic        HREADYOUT_SRAM;
  logic        HREADYOUT_SUB;
  logic        HRESP_CODE;
  logic        HRESP_SRAM;
  logic        HRESP_SUB;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HREADY,
    output HREADYOUT, HRESP,
    output HADDR_O, HTRANS_O, HWRITE_O, HSIZE_O, HBURST_O, HPROT_O,
    output REQ_CODE, REQ_SRAM, REQ_SUB,
    input  ACTIVE_CODE, ACTIVE_SRAM, ACTIVE_SUB,
    input  HREADYOUT_CODE, HREADYOUT_SRAM, HREADYOUT_SUB,
    input  HRESP_CODE, HRESP_SRAM, HRESP_SUB
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HREADY,
    input  HREADYOUT, HRESP,
    input  HADDR_O, HTRANS_O, HWRITE_O, HSIZE_O, HBURST_O, HPROT_O,
    input  REQ_CODE, REQ_SRAM, REQ_SUB,
    output ACTIVE_CODE, ACTIVE_SRAM, ACTIVE_SUB,
    output HREADYOUT_CODE, HREADYOUT_SRAM, HREADYOUT_SUB,
    output HRESP_CODE, HRESP_SRAM, HRESP_SUB
  );
endinterface

// File: rtl/ahblite_busmatrix_inputstage_sys.sv
// SYS input stage: decodes the master address phase, holds it while the target
// output stage is busy, and routes the data-phase response back to the master.
module ahblite_busmatrix_inputstage_sys (
  input logic                               HCLK,
  input logic                               HRESETn,
  ahblite_busmatrix_inputstage_sys_if.slave bus
);

  typedef enum logic [1:0] {
    TGT_CODE = 2'd0,
    TGT_SRAM = 2'd1,
    TGT_SUB  = 2'd2,
    TGT_NONE = 2'd3
  } tgt_e;

  typedef enum logic [2:0] {
    DP_NONE = 3'd0,
    DP_CODE = 3'd1,
    DP_SRAM = 3'd2,
    DP_SUB  = 3'd3,
    DP_ERR1 = 3'd4,
    DP_ERR2 = 3'd5
  } dp_e;

  function automatic dp_e tgt_to_dp(tgt_e t);
    case (t)
      TGT_CODE: return DP_CODE;
      TGT_SRAM: return DP_SRAM;
      TGT_SUB:  return DP_SUB;
      default:  return DP_NONE;
    endcase
  endfunction

  function automatic logic active_of(tgt_e t, logic a_code, logic a_sram, logic a_sub);
    case (t)
      TGT_CODE: return a_code;
      TGT_SRAM: return a_sram;
      TGT_SUB:  return a_sub;
      default:  return 1'b0;
    endcase
  endfunction

  logic        pend;
  tgt_e        hold_tgt_p1;
  logic [31:0] hold_addr_p1;
  logic [1:0]  hold_trans_p1;
  logic        hold_write_p1;
  logic [2:0]  hold_size_p1;
  logic [2:0]  hold_burst_p1;
  logic [3:0]  hold_prot_p1;

  dp_e  dp, dp_nxt;
  tgt_e live_tgt, req_tgt;
  logic valid, live_mapped, live_active, held_active;
  logic accept_live, capture, release_held, err_valid;
  logic hready_out, hresp_out;

  // Address phase decode
  always_comb begin
    live_tgt = TGT_NONE;
    case (bus.HADDR[31:29])
      3'b000:  live_tgt = TGT_CODE;
      3'b001:  live_tgt = TGT_SRAM;
      3'b010:  live_tgt = TGT_SUB;
      default: live_tgt = TGT_NONE;
    endcase
  end

  assign valid        = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign live_mapped  = (live_tgt != TGT_NONE);
  assign live_active  = active_of(live_tgt, bus.ACTIVE_CODE, bus.ACTIVE_SRAM, bus.ACTIVE_SUB);
  assign held_active  = active_of(hold_tgt_p1, bus.ACTIVE_CODE, bus.ACTIVE_SRAM, bus.ACTIVE_SUB);

  assign accept_live  = ~pend & valid & live_mapped & live_active;
  assign capture      = ~pend & valid & live_mapped & ~live_active;
  assign release_held = pend & held_active;
  assign err_valid    = ~pend & valid & ~live_mapped;

  // Holding register: only loaded when empty, so it is stable for the whole wait
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend          <= 1'b0;
      hold_tgt_p1   <= TGT_CODE;
      hold_addr_p1  <= '0;
      hold_trans_p1 <= '0;
      hold_write_p1 <= 1'b0;
      hold_size_p1  <= '0;
      hold_burst_p1 <= '0;
      hold_prot_p1  <= '0;
    end else if (capture) begin
      pend          <= 1'b1;
      hold_tgt_p1   <= live_tgt;
      hold_addr_p1  <= bus.HADDR;
      hold_trans_p1 <= bus.HTRANS;
      hold_write_p1 <= bus.HWRITE;
      hold_size_p1  <= bus.HSIZE;
      hold_burst_p1 <= bus.HBURST;
      hold_prot_p1  <= bus.HPROT;
    end else if (release_held) begin
      pend          <= 1'b0;
    end
  end

  assign bus.HADDR_O  = pend ? hold_addr_p1  : bus.HADDR;
  assign bus.HTRANS_O = pend ? hold_trans_p1 : bus.HTRANS;
  assign bus.HWRITE_O = pend ? hold_write_p1 : bus.HWRITE;
  assign bus.HSIZE_O  = pend ? hold_size_p1  : bus.HSIZE;
  assign bus.HBURST_O = pend ? hold_burst_p1 : bus.HBURST;
  assign bus.HPROT_O  = pend ? hold_prot_p1  : bus.HPROT;

  assign req_tgt      = pend ? hold_tgt_p1 : (valid ? live_tgt : TGT_NONE);
  assign bus.REQ_CODE = HRESETn & (req_tgt == TGT_CODE);
  assign bus.REQ_SRAM = HRESETn & (req_tgt == TGT_SRAM);
  assign bus.REQ_SUB  = HRESETn & (req_tgt == TGT_SUB);

  // Data-phase owner
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) dp <= DP_NONE;
    else          dp <= dp_nxt;
  end

  // A captured transfer has no data phase yet, so the owner drops to NONE until release
  always_comb begin
    dp_nxt = dp;
    if (release_held)      dp_nxt = tgt_to_dp(hold_tgt_p1);
    else if (accept_live)  dp_nxt = tgt_to_dp(live_tgt);
    else if (capture)      dp_nxt = DP_NONE;
    else if (err_valid)    dp_nxt = DP_ERR1;
    else if (dp == DP_ERR1) dp_nxt = DP_ERR2;
    else if (hready_out)   dp_nxt = DP_NONE;
  end

  always_comb begin
    hready_out = 1'b1;
    hresp_out  = 1'b0;
    if (pend) begin
      hready_out = 1'b0;
      hresp_out  = 1'b0;
    end else begin
      case (dp)
        DP_ERR1: begin hready_out = 1'b0;               hresp_out = 1'b1;            end
        DP_ERR2: begin hready_out = 1'b1;               hresp_out = 1'b1;            end
        DP_CODE: begin hready_out = bus.HREADYOUT_CODE; hresp_out = bus.HRESP_CODE;  end
        DP_SRAM: begin hready_out = bus.HREADYOUT_SRAM; hresp_out = bus.HRESP_SRAM;  end
        DP_SUB:  begin hready_out = bus.HREADYOUT_SUB;  hresp_out = bus.HRESP_SUB;   end
        default: begin hready_out = 1'b1;               hresp_out = 1'b0;            end
      endcase
    end
  end

  assign bus.HREADYOUT = hready_out;
  assign bus.HRESP     = hresp_out;

endmodule

// File: tb/tb_ahblite_busmatrix_inputstage_sys.sv
// Directed bench for the SYS input stage; single-master layer, so HREADY is
// looped back from HREADYOUT.
module tb_ahblite_busmatrix_inputstage_sys;

  logic HCLK;
  logic HRESETn;
  int   n_assert;
  int   n_fail;

  ahblite_busmatrix_inputstage_sys_if bus ();

  ahblite_busmatrix_inputstage_sys dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.slave)
  );

  assign bus.HREADY = bus.HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    bus.HSEL           = 1'b0;
    bus.HADDR          = 32'h0;
    bus.HTRANS         = 2'b00;
    bus.HWRITE         = 1'b0;
    bus.HSIZE          = 3'b010;
    bus.HBURST         = 3'b000;
    bus.HPROT          = 4'b0011;
    bus.ACTIVE_CODE    = 1'b0;
    bus.ACTIVE_SRAM    = 1'b0;
    bus.ACTIVE_SUB     = 1'b0;
    bus.HREADYOUT_CODE = 1'b1;
    bus.HREADYOUT_SRAM = 1'b1;
    bus.HREADYOUT_SUB  = 1'b1;
    bus.HRESP_CODE     = 1'b0;
    bus.HRESP_SRAM     = 1'b0;
    bus.HRESP_SUB      = 1'b0;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic [1:0] t, input logic w);
    bus.HSEL   = 1'b1;
    bus.HADDR  = a;
    bus.HTRANS = t;
    bus.HWRITE = w;
  endtask

  function automatic logic [31:0] reqs();
    return {29'd0, bus.REQ_CODE, bus.REQ_SRAM, bus.REQ_SUB};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    idle_inputs();
    HRESETn = 1'b1;
    #1 HRESETn = 1'b0;

    // In reset with a live valid SUB transfer: forwarded, but no request
    addr_phase(32'h4000_0004, 2'b10, 1'b0);
    settle();
    check_eq("rst_hreadyout", bus.HREADYOUT, 1);
    check_eq("rst_hresp",     bus.HRESP, 0);
    check_eq("rst_reqs",      reqs(), 0);
    check_eq("rst_haddr_o",   bus.HADDR_O, 32'h4000_0004);
    step();
    step();
    idle_inputs();
    HRESETn = 1'b1;
    settle();
    check_eq("post_rst_ready", bus.HREADYOUT, 1);

    // Accept in the same cycle to SRAM
    addr_phase(32'h2000_0010, 2'b10, 1'b1);
    bus.ACTIVE_SRAM = 1'b1;
    settle();
    check_eq("sram_req",     reqs(), 3'b010);
    check_eq("sram_ready",   bus.HREADYOUT, 1);
    check_eq("sram_haddr_o", bus.HADDR_O, 32'h2000_0010);
    step();
    idle_inputs();
    bus.HREADYOUT_SRAM = 1'b0;
    settle();
    check_eq("sram_dp_wait", bus.HREADYOUT, 0);
    check_eq("sram_dp_req",  reqs(), 0);
    step();
    bus.HREADYOUT_SRAM = 1'b1;
    settle();
    check_eq("sram_dp_done", bus.HREADYOUT, 1);
    step();
    bus.HREADYOUT_SRAM = 1'b0;
    settle();
    check_eq("sram_dp_none", bus.HREADYOUT, 1);
    idle_inputs();

    // SUB target busy: capture and hold for three cycles
    addr_phase(32'h4000_0004, 2'b10, 1'b1);
    settle();
    check_eq("sub_req_live", reqs(), 3'b001);
    step();
    idle_inputs();
    bus.HADDR = 32'hDEAD_0000;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("sub_hold_addr",  bus.HADDR_O, 32'h4000_0004);
      check_eq("sub_hold_trans", bus.HTRANS_O, 2'b10);
      check_eq("sub_hold_write", bus.HWRITE_O, 1);
      check_eq("sub_hold_req",   reqs(), 3'b001);
      check_eq("sub_hold_ready", bus.HREADYOUT, 0);
      step();
    end
    bus.ACTIVE_SUB = 1'b1;
    settle();
    check_eq("sub_rel_req",   reqs(), 3'b001);
    check_eq("sub_rel_ready", bus.HREADYOUT, 0);
    step();
    bus.ACTIVE_SUB    = 1'b0;
    bus.HREADYOUT_SUB = 1'b0;
    bus.HRESP_SUB     = 1'b1;
    settle();
    check_eq("sub_dp_ready", bus.HREADYOUT, 0);
    check_eq("sub_dp_resp",  bus.HRESP, 1);
    check_eq("sub_dp_req",   reqs(), 0);
    check_eq("sub_dp_addr",  bus.HADDR_O, 32'hDEAD_0000);
    step();
    bus.HREADYOUT_SUB = 1'b1;
    bus.HRESP_SUB     = 1'b0;
    settle();
    check_eq("sub_dp_done", {bus.HREADYOUT, bus.HRESP}, 2'b10);
    step();

    // Unmapped address: two-cycle error response
    addr_phase(32'hE000_0000, 2'b10, 1'b0);
    settle();
    check_eq("err_reqs",  reqs(), 0);
    check_eq("err_ready", bus.HREADYOUT, 1);
    step();
    idle_inputs();
    settle();
    check_eq("err1_resp", {bus.HREADYOUT, bus.HRESP}, 2'b01);
    step();
    settle();
    check_eq("err2_resp", {bus.HREADYOUT, bus.HRESP}, 2'b11);
    step();
    settle();
    check_eq("err_idle",  {bus.HREADYOUT, bus.HRESP}, 2'b10);

    // CODE burst with a two-cycle data-phase stall
    addr_phase(32'h0000_0100, 2'b10, 1'b0);
    bus.ACTIVE_CODE = 1'b1;
    settle();
    check_eq("code_req0", reqs(), 3'b100);
    step();
    addr_phase(32'h0000_0104, 2'b11, 1'b0);
    bus.HREADYOUT_CODE = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check_eq("code_stall_ready", bus.HREADYOUT, 0);
      check_eq("code_stall_req",   reqs(), 0);
      step();
    end
    bus.HREADYOUT_CODE = 1'b1;
    settle();
    check_eq("code_seq_req",   reqs(), 3'b100);
    check_eq("code_seq_ready", bus.HREADYOUT, 1);
    check_eq("code_seq_addr",  bus.HADDR_O, 32'h0000_0104);
    check_eq("code_seq_trans", bus.HTRANS_O, 2'b11);
    step();
    idle_inputs();
    bus.HREADYOUT_CODE = 1'b0;
    settle();
    check_eq("code_seq_dp", bus.HREADYOUT, 0);
    step();
    bus.HREADYOUT_CODE = 1'b1;
    settle();
    check_eq("code_seq_done", bus.HREADYOUT, 1);
    step();

    // Reset while a SUB transfer is pending
    addr_phase(32'h4000_0008, 2'b10, 1'b1);
    step();
    idle_inputs();
    settle();
    check_eq("rstp_pend_req",   reqs(), 3'b001);
    check_eq("rstp_pend_ready", bus.HREADYOUT, 0);
    HRESETn = 1'b0;
    #1;
    check_eq("rstp_req",   reqs(), 0);
    check_eq("rstp_resp",  {bus.HREADYOUT, bus.HRESP}, 2'b10);
    step();
    HRESETn = 1'b1;
    settle();
    check_eq("rstp_rel_req",   reqs(), 0);
    check_eq("rstp_rel_resp",  {bus.HREADYOUT, bus.HRESP}, 2'b10);
    check_eq("rstp_rel_trans", bus.HTRANS_O, 2'b00);
    step();
    settle();
    check_eq("rstp_after_resp", {bus.HREADYOUT, bus.HRESP}, 2'b10);

    // Spurious accept strobe with IDLE and BUSY transfers
    bus.HSEL        = 1'b1;
    bus.HTRANS      = 2'b00;
    bus.ACTIVE_CODE = 1'b1;
    settle();
    check_eq("spur_idle_req", reqs(), 0);
    step();
    bus.HTRANS         = 2'b01;
    bus.HREADYOUT_CODE = 1'b0;
    settle();
    check_eq("spur_dp_none",  bus.HREADYOUT, 1);
    check_eq("spur_busy_req", reqs(), 0);
    step();
    settle();
    check_eq("spur_final", {bus.HREADYOUT, bus.HRESP}, 2'b10);
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
